// File: rtl/rename_pkg.sv
// Shared definitions for the register-rename stage: architectural register
// geometry and the architectural-side instruction bundle.
package rename_pkg;

  localparam int ARCH_REGS = 32;
  localparam int AREG_W    = 5;

  typedef struct packed {
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic              reg_write;
  } arch_inst_t;

  // x0 is hard-wired, so a write to it never allocates.
  function automatic logic writes_rd(input arch_inst_t inst);
    return inst.reg_write && (inst.rd != '0);
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical registers; one pop and one push per cycle.
// Reset contents are ARCH_REGS..NUM_PREGS-1 in ascending order.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int CNT_W     = $clog2(NUM_PREGS - 31)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pop,
  input  logic              push,
  input  logic [PREG_W-1:0] push_preg,
  output logic [PREG_W-1:0] head_preg,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int               DEPTH   = NUM_PREGS - ARCH_REGS;
  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PREG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop, do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign head_preg = mem_q[head_q];
  assign do_pop    = pop && !empty;
  // Pushing into a full list is illegal; the entry is dropped.
  assign do_push   = push && !full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop) head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    if (do_push) begin
      mem_d[tail_q] = push_preg;
      tail_d        = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage is flops, not a RAM macro, because reset must load the initial free set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PREG_W'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DEPTH_C;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("free list overflow: push of preg %0d while full", push_preg);

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup/update, free-list allocation and a single
// registered output slot with valid/ready. Optional: RENAME_FREE_BYPASS_EN
// lets a retiring register be allocated in the same cycle when the list is empty.
module rename_stage
  import rename_pkg::*;
#(
  parameter  int NUM_PREGS = 64,
  parameter  int CTRL_W    = 40,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int CNT_W     = $clog2(NUM_PREGS - 31)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_reg_write,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              retire_valid,
  input  logic [PREG_W-1:0] retire_preg,
  output logic [CNT_W-1:0]  free_count
);

  arch_inst_t        in_inst;
  logic [PREG_W-1:0] rat_q [ARCH_REGS];
  logic [PREG_W-1:0] rat_d [ARCH_REGS];

  logic              out_valid_q, out_valid_d;
  logic [PREG_W-1:0] out_prs1_q, out_prs1_d;
  logic [PREG_W-1:0] out_prs2_q, out_prs2_d;
  logic [PREG_W-1:0] out_prd_q, out_prd_d;
  logic [PREG_W-1:0] out_old_prd_q, out_old_prd_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;

  logic              fl_pop, fl_push, fl_empty, fl_full;
  logic [PREG_W-1:0] fl_head;
  logic              stage_free, retire_req, bypass_hit, fire, alloc;
  logic [PREG_W-1:0] new_prd;

  assign in_inst    = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, reg_write: in_reg_write};
  assign stage_free = !out_valid_q || out_ready;
  assign retire_req = retire_valid && (retire_preg != '0);

`ifdef RENAME_FREE_BYPASS_EN
  assign bypass_hit = fl_empty && retire_req;
`else
  assign bypass_hit = 1'b0;
`endif

  // Ready ignores in_valid/in_rd: non-writers stall on an empty list too.
  assign in_ready = stage_free && (!fl_empty || bypass_hit);
  assign fire     = in_valid && in_ready;
  assign alloc    = fire && writes_rd(in_inst);
  assign new_prd  = bypass_hit ? retire_preg : fl_head;
  assign fl_pop   = alloc && !bypass_hit;
  assign fl_push  = retire_req && !(alloc && bypass_hit);

  rename_free_list #(
    .NUM_PREGS (NUM_PREGS),
    .PREG_W    (PREG_W),
    .CNT_W     (CNT_W)
  ) u_free_list (
    .clk       (clk),
    .rst_n     (rst_n),
    .pop       (fl_pop),
    .push      (fl_push),
    .push_preg (retire_preg),
    .head_preg (fl_head),
    .empty     (fl_empty),
    .full      (fl_full),
    .count     (free_count)
  );

  always_comb begin
    rat_d           = rat_q;
    out_valid_d     = out_valid_q;
    out_prs1_d      = out_prs1_q;
    out_prs2_d      = out_prs2_q;
    out_prd_d       = out_prd_q;
    out_old_prd_d   = out_old_prd_q;
    out_reg_write_d = out_reg_write_q;
    out_ctrl_d      = out_ctrl_q;
    if (stage_free) out_valid_d = fire;
    if (fire) begin
      // Sources read the pre-update RAT, so rs==rd sees the old mapping.
      out_prs1_d      = rat_q[in_inst.rs1];
      out_prs2_d      = rat_q[in_inst.rs2];
      out_ctrl_d      = in_ctrl;
      out_reg_write_d = alloc;
      out_prd_d       = alloc ? new_prd : '0;
      out_old_prd_d   = alloc ? rat_q[in_inst.rd] : '0;
      if (alloc) rat_d[in_inst.rd] = new_prd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PREG_W'(i);
      out_valid_q     <= 1'b0;
      out_prs1_q      <= '0;
      out_prs2_q      <= '0;
      out_prd_q       <= '0;
      out_old_prd_q   <= '0;
      out_reg_write_q <= 1'b0;
      out_ctrl_q      <= '0;
    end else begin
      rat_q           <= rat_d;
      out_valid_q     <= out_valid_d;
      out_prs1_q      <= out_prs1_d;
      out_prs2_q      <= out_prs2_d;
      out_prd_q       <= out_prd_d;
      out_old_prd_q   <= out_old_prd_d;
      out_reg_write_q <= out_reg_write_d;
      out_ctrl_q      <= out_ctrl_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_prs1      = out_prs1_q;
  assign out_prs2      = out_prs2_q;
  assign out_prd       = out_prd_q;
  assign out_old_prd   = out_old_prd_q;
  assign out_reg_write = out_reg_write_q;
  assign out_ctrl      = out_ctrl_q;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage with a reference RAT/free-list model and an
// output scoreboard; honours RENAME_FREE_BYPASS_EN when defined.
module tb_rename_stage;

  localparam int NUM_PREGS = 64;
  localparam int CTRL_W    = 40;
  localparam int PREG_W    = 6;
  localparam int CNT_W     = 6;

  typedef struct {
    logic [PREG_W-1:0] prs1, prs2, prd, old;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  logic              clk, rst_n;
  logic              in_valid, in_ready, in_reg_write;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid, out_ready, out_reg_write;
  logic [PREG_W-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic [CTRL_W-1:0] out_ctrl;
  logic              retire_valid;
  logic [PREG_W-1:0] retire_preg;
  logic [CNT_W-1:0]  free_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ctrl_seq = 0;
  int   mrat [32];
  int   free_q [$];
  int   reclaim [$];
  exp_t sb [$];

  rename_stage #(.NUM_PREGS(NUM_PREGS), .CTRL_W(CTRL_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_ctrl       (in_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_prs1      (out_prs1),
    .out_prs2      (out_prs2),
    .out_prd       (out_prd),
    .out_old_prd   (out_old_prd),
    .out_reg_write (out_reg_write),
    .out_ctrl      (out_ctrl),
    .retire_valid  (retire_valid),
    .retire_preg   (retire_preg),
    .free_count    (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrat[i] = i;
    free_q.delete();
    for (int i = 32; i < NUM_PREGS; i++) free_q.push_back(i);
    sb.delete();
    reclaim.delete();
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input int rd, input logic w);
    in_valid     = v;
    in_rs1       = 5'(rs1);
    in_rs2       = 5'(rs2);
    in_rd        = 5'(rd);
    in_reg_write = w;
    in_ctrl      = {8'hC3, 32'(ctrl_seq)};
    ctrl_seq++;
  endtask

  // Checks current-cycle outputs against the model, advances the model by the
  // upcoming clock edge, then moves to the next falling edge.
  task automatic tick();
    logic exp_ready, fire, wr, took;
    exp_t e;
    #1;
    exp_ready = (sb.size() == 0 || out_ready) && (free_q.size() != 0);
`ifdef RENAME_FREE_BYPASS_EN
    if ((sb.size() == 0 || out_ready) && free_q.size() == 0 && retire_valid && retire_preg != 0)
      exp_ready = 1'b1;
`endif
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, sb.size() != 0);
    check("free_count", free_count, free_q.size());
    if (sb.size() != 0) begin
      check("out_prs1", out_prs1, sb[0].prs1);
      check("out_prs2", out_prs2, sb[0].prs2);
      check("out_prd", out_prd, sb[0].prd);
      check("out_old_prd", out_old_prd, sb[0].old);
      check("out_reg_write", out_reg_write, sb[0].wr);
      check("out_ctrl", out_ctrl, sb[0].ctrl);
      if (out_ready) begin
        e = sb.pop_front();
        if (e.wr) reclaim.push_back(int'(e.old));
      end
    end
    fire = in_valid && exp_ready;
    took = 1'b0;
    if (fire) begin
      wr     = in_reg_write && (in_rd != 0);
      e.prs1 = PREG_W'(mrat[in_rs1]);
      e.prs2 = PREG_W'(mrat[in_rs2]);
      e.ctrl = in_ctrl;
      e.wr   = wr;
      e.prd  = '0;
      e.old  = '0;
      if (wr) begin
        if (free_q.size() != 0) e.prd = PREG_W'(free_q.pop_front());
        else begin
          e.prd = retire_preg;
          took  = 1'b1;
        end
        e.old       = PREG_W'(mrat[in_rd]);
        mrat[in_rd] = int'(e.prd);
      end
      sb.push_back(e);
    end
    if (retire_valid && retire_preg != 0 && !took) free_q.push_back(int'(retire_preg));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    out_ready    = 1'b1;
    retire_valid = 1'b0;
    retire_preg  = '0;
    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_free_count", free_count, 32);
    check("rst_out_prd", out_prd, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_in_ready", in_ready, 1);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // First rename
    drive(1'b1, 3, 4, 5, 1'b1);
    tick();
    check("t1_prs1", out_prs1, 3);
    check("t1_prs2", out_prs2, 4);
    check("t1_prd", out_prd, 32);
    check("t1_old_prd", out_old_prd, 5);
    check("t1_free_count", free_count, 31);

    // Back-to-back writes to x5, then a dependent reader
    drive(1'b1, 0, 0, 5, 1'b1);
    tick();
    check("t2_prd", out_prd, 33);
    check("t2_old_prd", out_old_prd, 32);
    drive(1'b1, 5, 0, 0, 1'b0);
    tick();
    check("t3_prs1", out_prs1, 33);
    check("t3_reg_write", out_reg_write, 0);

    // rd = x0 with reg_write set
    drive(1'b1, 1, 2, 0, 1'b1);
    tick();
    check("x0_reg_write", out_reg_write, 0);
    check("x0_prd", out_prd, 0);
    check("x0_old_prd", out_old_prd, 0);
    check("x0_free_count", free_count, 30);

    // Backpressure: hold one output for three cycles
    drive(1'b1, 6, 7, 8, 1'b1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 9, 10, 11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_prd", out_prd, 34);
      check("stall_in_ready", in_ready, 0);
      check("stall_free_count", free_count, 29);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    check("release_out_valid", out_valid, 0);

    // Drain the free list
    for (int i = 0; i < 64 && free_q.size() != 0; i++) begin
      drive(1'b1, i % 32, (i + 7) % 32, (i % 31) + 1, 1'b1);
      tick();
    end
    drive(1'b1, 1, 2, 12, 1'b1);
    #1;
    check("empty_in_ready", in_ready, 0);
    check("empty_free_count", free_count, 0);
    retire_valid = 1'b1;
    retire_preg  = 6'd7;
`ifdef RENAME_FREE_BYPASS_EN
    #1;
    check("bypass_in_ready", in_ready, 1);
    tick();
    retire_valid = 1'b0;
    check("bypass_prd", out_prd, 7);
    check("bypass_free_count", free_count, 0);
`else
    #1;
    check("retire_cycle_in_ready", in_ready, 0);
    tick();
    retire_valid = 1'b0;
    #1;
    check("after_retire_in_ready", in_ready, 1);
    tick();
    check("after_retire_prd", out_prd, 7);
    check("after_retire_free_count", free_count, 0);
`endif

    // Refill to ten free entries
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      retire_valid = 1'b1;
      retire_preg  = PREG_W'(reclaim.pop_front());
      tick();
    end
    retire_valid = 1'b0;
    tick();
    check("refill_free_count", free_count, 10);

    // Paired allocate + retire across pointer wrap
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, (i + 3) % 32, (i + 11) % 32, (i % 31) + 1, 1'b1);
      retire_valid = (reclaim.size() != 0);
      retire_preg  = (reclaim.size() != 0) ? PREG_W'(reclaim.pop_front()) : '0;
      tick();
      check("pair_free_count", free_count, 10);
    end
    retire_valid = 1'b0;
    in_valid     = 1'b0;

    // Reset with an output in flight
    drive(1'b1, 4, 5, 6, 1'b1);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_free_count", free_count, 32);
    check("midrst_out_prd", out_prd, 0);
    model_reset();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 9, 3, 9, 1'b1);
    tick();
    check("postrst_prs1", out_prs1, 9);
    check("postrst_prd", out_prd, 32);
    check("postrst_old_prd", out_old_prd, 9);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
